// File: rtl/m_drop_controller.sv
// Move sequencer for the 7x6 drop-piece game: column check, pile/board update, turn alternation.
// Optional drop animation (FALL state paced by i_tick) is enabled with `DROP_ANIM_EN.

// One column of the pile counter: compares against the requested column and bumps its count.
module m_pile_lane #(
    parameter int CW   = 3,
    parameter int LANE = 0,
    parameter int ROWS = 6
) (
    input  logic [CW-1:0] cnt,
    input  logic [2:0]    col,
    output logic          sel,
    output logic          full,
    output logic [CW-1:0] cnt_nxt
);
    assign sel     = (col == 3'(LANE));
    assign full    = (cnt == CW'(ROWS));
    assign cnt_nxt = (sel && !full) ? cnt + CW'(1) : cnt;
endmodule

// Combinational check/increment of the packed pile-count array for one requested column.
module m_pile_counter #(
    parameter int NUM_COLS = 7,
    parameter int COL_W    = 3,
    parameter int ROWS     = 6
) (
    input  logic [NUM_COLS*COL_W-1:0] pile_in,
    input  logic [2:0]                col,
    output logic                      legal,
    output logic [COL_W-1:0]          land_row,
    output logic [NUM_COLS*COL_W-1:0] pile_out
);
    logic [NUM_COLS-1:0]            sel;
    logic [NUM_COLS-1:0]            full;
    logic [NUM_COLS-1:0][COL_W-1:0] cnt;
    logic [NUM_COLS-1:0][COL_W-1:0] cnt_nxt;

    assign cnt      = pile_in;
    assign pile_out = cnt_nxt;

    genvar g;
    generate
        for (g = 0; g < NUM_COLS; g++) begin : g_lane
            m_pile_lane #(.CW(COL_W), .LANE(g), .ROWS(ROWS)) u_lane (
                .cnt     (cnt[g]),
                .col     (col),
                .sel     (sel[g]),
                .full    (full[g]),
                .cnt_nxt (cnt_nxt[g])
            );
        end
    endgenerate

    // A column outside 0..6 selects no lane, so it falls out as illegal.
    always_comb begin
        legal    = 1'b0;
        land_row = '0;
        for (int i = 0; i < NUM_COLS; i++) begin
            if (sel[i]) begin
                legal    = !full[i];
                land_row = cnt[i];
            end
        end
    end
endmodule

module m_drop_controller #(
    parameter logic FIRST_PLAYER   = 1'b0,
    parameter int   ANIM_ROW_TICKS = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clear,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [2:0]  i_req_col,
    output logic        o_resp_valid,
    output logic        o_resp_ok,
    output logic [2:0]  o_resp_row,
    output logic        o_player,
    output logic [20:0] o_pile_count_array,
    output logic [41:0] o_board_p0,
    output logic [41:0] o_board_p1,
    output logic        o_full,
    input  logic        i_tick,
    output logic        o_anim_valid,
    output logic [2:0]  o_anim_col,
    output logic [2:0]  o_anim_row
);
    localparam int COL_SIZE              = 3;
    localparam int ROW_SIZE              = 3;
    localparam int PILE_COUNT_ARRAY_SIZE = 21;
    localparam int NUM_COLS              = 7;
    localparam int NUM_ROWS              = 6;
    localparam int NUM_CELLS             = 42;
    localparam logic [5:0] CELLS_FULL    = 6'd42;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHECK  = 3'd1,
        S_FALL   = 3'd2,
        S_COMMIT = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    state_t                           state, state_nxt;
    logic [COL_SIZE-1:0]              col_q;
    logic                             legal_q;
    logic [ROW_SIZE-1:0]              land_q;
    logic [PILE_COUNT_ARRAY_SIZE-1:0] pile_q;
    logic [NUM_CELLS-1:0]             board_p0_q;
    logic [NUM_CELLS-1:0]             board_p1_q;
    logic [5:0]                       move_cnt;
    logic                             player_q;

    logic                             pc_legal;
    logic [ROW_SIZE-1:0]              pc_land;
    logic [PILE_COUNT_ARRAY_SIZE-1:0] pc_pile;
    logic                             hs;
    logic [5:0]                       cell_idx;
    logic [NUM_CELLS-1:0]             cell_mask;

    m_pile_counter #(.NUM_COLS(NUM_COLS), .COL_W(COL_SIZE), .ROWS(NUM_ROWS)) u_pile_counter (
        .pile_in  (pile_q),
        .col      (col_q),
        .legal    (pc_legal),
        .land_row (pc_land),
        .pile_out (pc_pile)
    );

    assign o_full      = (move_cnt == CELLS_FULL);
    assign o_req_ready = (state == S_IDLE) && !o_full;
    assign hs          = i_req_valid && o_req_ready;

    // Only reached for legal moves, so col_q <= 6 and land_q <= 5 keep the index below 42.
    assign cell_idx  = ({3'b000, land_q} * 6'd7) + {3'b000, col_q};
    assign cell_mask = {{(NUM_CELLS-1){1'b0}}, 1'b1} << cell_idx;

`ifdef DROP_ANIM_EN
    localparam int TICK_W = (ANIM_ROW_TICKS > 1) ? $clog2(ANIM_ROW_TICKS) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(ANIM_ROW_TICKS - 1);

    logic [TICK_W-1:0]   tick_cnt;
    logic [ROW_SIZE-1:0] anim_row_q;
    logic                row_tick;
    logic                fall_done;

    assign row_tick  = i_tick && (tick_cnt == TICK_LAST);
    assign fall_done = row_tick && (anim_row_q <= land_q);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            tick_cnt   <= '0;
            anim_row_q <= '0;
        end else if (state == S_CHECK) begin
            tick_cnt   <= '0;
            anim_row_q <= 3'd5;
        end else if (state == S_FALL && i_tick) begin
            if (row_tick) begin
                tick_cnt <= '0;
                if (anim_row_q > land_q)
                    anim_row_q <= anim_row_q - 3'd1;
            end else begin
                tick_cnt <= tick_cnt + TICK_W'(1);
            end
        end
    end

    assign o_anim_valid = (state == S_FALL);
    assign o_anim_col   = o_anim_valid ? col_q : 3'd0;
    assign o_anim_row   = o_anim_valid ? anim_row_q : 3'd0;
`else
    logic unused_anim;
    assign unused_anim  = i_tick ^ (ANIM_ROW_TICKS < 1);
    assign o_anim_valid = 1'b0;
    assign o_anim_col   = 3'd0;
    assign o_anim_row   = 3'd0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (hs) state_nxt = S_CHECK;
            S_CHECK: begin
                if (!pc_legal)
                    state_nxt = S_RESP;
                else
`ifdef DROP_ANIM_EN
                    state_nxt = S_FALL;
`else
                    state_nxt = S_COMMIT;
`endif
            end
`ifdef DROP_ANIM_EN
            S_FALL:   if (fall_done) state_nxt = S_COMMIT;
`else
            S_FALL:   state_nxt = S_IDLE;
`endif
            S_COMMIT: state_nxt = S_RESP;
            S_RESP:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Clear shares the reset path so an in-flight move is dropped without a response.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            state      <= S_IDLE;
            col_q      <= '0;
            legal_q    <= 1'b0;
            land_q     <= '0;
            pile_q     <= '0;
            board_p0_q <= '0;
            board_p1_q <= '0;
            move_cnt   <= '0;
            player_q   <= FIRST_PLAYER;
        end else begin
            state <= state_nxt;
            if (hs)
                col_q <= i_req_col;
            if (state == S_CHECK) begin
                legal_q <= pc_legal;
                land_q  <= pc_legal ? pc_land : '0;
            end
            if (state == S_COMMIT) begin
                pile_q <= pc_pile;
                if (player_q)
                    board_p1_q <= board_p1_q | cell_mask;
                else
                    board_p0_q <= board_p0_q | cell_mask;
                move_cnt <= move_cnt + 6'd1;
                player_q <= ~player_q;
            end
        end
    end

    assign o_resp_valid       = (state == S_RESP);
    assign o_resp_ok          = o_resp_valid && legal_q;
    assign o_resp_row         = o_resp_valid ? land_q : 3'd0;
    assign o_player           = player_q;
    assign o_pile_count_array = pile_q;
    assign o_board_p0         = board_p0_q;
    assign o_board_p1         = board_p1_q;
endmodule

// File: tb/tb_m_drop_controller.sv
// Directed self-checking bench for m_drop_controller (default build; anim scenario under `DROP_ANIM_EN).
module tb_m_drop_controller;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        req_valid = 1'b0;
    logic [2:0]  req_col = 3'd0;
    logic        tick = 1'b0;
    logic        tick_auto = 1'b1;
    logic        req_ready, resp_valid, resp_ok, player, full, anim_valid;
    logic [2:0]  resp_row, anim_col, anim_row;
    logic [20:0] pile;
    logic [41:0] board_p0, board_p1;

    int tests = 0;
    int fails = 0;

    m_drop_controller #(.FIRST_PLAYER(1'b0), .ANIM_ROW_TICKS(2)) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_clear            (clear),
        .i_req_valid        (req_valid),
        .o_req_ready        (req_ready),
        .i_req_col          (req_col),
        .o_resp_valid       (resp_valid),
        .o_resp_ok          (resp_ok),
        .o_resp_row         (resp_row),
        .o_player           (player),
        .o_pile_count_array (pile),
        .o_board_p0         (board_p0),
        .o_board_p1         (board_p1),
        .o_full             (full),
        .i_tick             (tick),
        .o_anim_valid       (anim_valid),
        .o_anim_col         (anim_col),
        .o_anim_row         (anim_row)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk); #1;
            if (tick_auto) tick = ~tick;
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input logic use_clear);
        if (use_clear) clear = 1'b1; else rst = 1'b1;
        req_valid = 1'b0;
        cyc(); cyc();
        rst = 1'b0; clear = 1'b0;
        cyc();
    endtask

    // Drives one request and returns what was observed; callers do their own comparisons.
    task automatic do_req(input logic [2:0] col, output logic seen, output logic ok,
                          output logic [2:0] row, output int lat, output logic rdy_after);
        int n;
        seen = 1'b0; ok = 1'b0; row = 3'd0; lat = -1; rdy_after = 1'b0;
        req_valid = 1'b1; req_col = col; n = 0;
        while (!req_ready && n < 50) begin cyc(); n++; end
        if (!req_ready) begin req_valid = 1'b0; return; end
        cyc();
        req_valid = 1'b0; n = 0;
        while (!resp_valid && n < 300) begin cyc(); n++; end
        if (!resp_valid) return;
        seen = resp_valid; ok = resp_ok; row = resp_row; lat = n;
        cyc();
        rdy_after = req_ready;
    endtask

    task automatic test_reset();
        do_reset(1'b0);
        tests++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_ok !== 1'b0 || resp_row !== 3'd0 || full !== 1'b0) begin
            fails++; $display("FAIL reset_ctrl: ready=%b rv=%b ok=%b row=%0d full=%b, want 1 0 0 0 0", req_ready, resp_valid, resp_ok, resp_row, full);
        end
        tests++;
        if (player !== 1'b0 || pile !== 21'd0 || board_p0 !== 42'd0 || board_p1 !== 42'd0) begin
            fails++; $display("FAIL reset_state: player=%b pile=%h p0=%h p1=%h, want all 0", player, pile, board_p0, board_p1);
        end
        tests++;
        if (anim_valid !== 1'b0 || anim_col !== 3'd0 || anim_row !== 3'd0) begin
            fails++; $display("FAIL reset_anim: v=%b col=%0d row=%0d, want 0", anim_valid, anim_col, anim_row);
        end
    endtask

    task automatic test_first_move();
        logic seen, ok, rdy; logic [2:0] row; int lat;
        do_reset(1'b0);
        do_req(3'd3, seen, ok, row, lat, rdy);
        tests++;
        if (seen !== 1'b1 || ok !== 1'b1 || row !== 3'd0 || rdy !== 1'b1) begin
            fails++; $display("FAIL first_move_resp: seen=%b ok=%b row=%0d rdy=%b, want 1 1 0 1", seen, ok, row, rdy);
        end
`ifndef DROP_ANIM_EN
        tests++;
        if (lat !== 2) begin fails++; $display("FAIL first_move_latency: got %0d want 2", lat); end
`endif
        tests++;
        if (board_p0 !== 42'h8 || board_p1 !== 42'd0 || pile !== 21'h200 || player !== 1'b1) begin
            fails++; $display("FAIL first_move_state: p0=%h p1=%h pile=%h player=%b, want 8 0 200 1", board_p0, board_p1, pile, player);
        end
    endtask

    task automatic test_col_fill();
        logic seen, ok, rdy; logic [2:0] row; int lat;
        logic [41:0] bit_k;
        do_reset(1'b0);
        for (int k = 0; k < 7; k++) begin
            tests++;
            if (player !== ((k < 6) ? k[0] : 1'b0)) begin
                fails++; $display("FAIL col_fill_player_%0d: got %b want %b", k, player, (k < 6) ? k[0] : 1'b0);
            end
            do_req(3'd0, seen, ok, row, lat, rdy);
            tests++;
            if (seen !== 1'b1 || ok !== (k < 6) || row !== ((k < 6) ? 3'(k) : 3'd0)) begin
                fails++; $display("FAIL col_fill_resp_%0d: seen=%b ok=%b row=%0d, want 1 %b %0d", k, seen, ok, row, k < 6, (k < 6) ? k : 0);
            end
`ifndef DROP_ANIM_EN
            tests++;
            if (lat !== ((k < 6) ? 2 : 1)) begin
                fails++; $display("FAIL col_fill_lat_%0d: got %0d want %0d", k, lat, (k < 6) ? 2 : 1);
            end
`endif
            if (k < 6) begin
                bit_k = 42'd1 << (k * 7);
                tests++;
                if (((k[0] ? board_p1 : board_p0) & bit_k) === 42'd0 || ((k[0] ? board_p0 : board_p1) & bit_k) !== 42'd0) begin
                    fails++; $display("FAIL col_fill_board_%0d: p0=%h p1=%h", k, board_p0, board_p1);
                end
            end
        end
        tests++;
        if (player !== 1'b0 || pile !== 21'd6 || (board_p0 & board_p1) !== 42'd0) begin
            fails++; $display("FAIL col_fill_final: player=%b pile=%h overlap=%h, want 0 6 0", player, pile, board_p0 & board_p1);
        end
    endtask

    task automatic test_illegal_col();
        logic seen, ok, rdy; logic [2:0] row; int lat;
        logic [20:0] pile_b; logic [41:0] p0_b, p1_b; logic pl_b;
        pile_b = pile; p0_b = board_p0; p1_b = board_p1; pl_b = player;
        do_req(3'd7, seen, ok, row, lat, rdy);
        tests++;
        if (seen !== 1'b1 || ok !== 1'b0 || row !== 3'd0 || rdy !== 1'b1) begin
            fails++; $display("FAIL illegal_col_resp: seen=%b ok=%b row=%0d rdy=%b, want 1 0 0 1", seen, ok, row, rdy);
        end
        tests++;
        if (pile !== pile_b || board_p0 !== p0_b || board_p1 !== p1_b || player !== pl_b) begin
            fails++; $display("FAIL illegal_col_state: pile=%h p0=%h p1=%h pl=%b, want %h %h %h %b", pile, board_p0, board_p1, player, pile_b, p0_b, p1_b, pl_b);
        end
    endtask

    task automatic test_fill_board();
        logic seen, ok, rdy; logic [2:0] row; int lat; int bad; logic any_resp;
        do_reset(1'b0);
        bad = 0;
        for (int c = 0; c < 7; c++)
            for (int r = 0; r < 6; r++) begin
                do_req(3'(c), seen, ok, row, lat, rdy);
                if (seen !== 1'b1 || ok !== 1'b1 || row !== 3'(r)) bad++;
            end
        tests++;
        if (bad !== 0) begin fails++; $display("FAIL fill_moves: %0d bad responses, want 0", bad); end
        tests++;
        if (full !== 1'b1 || req_ready !== 1'b0) begin
            fails++; $display("FAIL fill_full: full=%b ready=%b, want 1 0", full, req_ready);
        end
        tests++;
        if ((board_p0 | board_p1) !== {42{1'b1}} || (board_p0 & board_p1) !== 42'd0 || $countones(board_p0) !== 21) begin
            fails++; $display("FAIL fill_boards: p0=%h p1=%h", board_p0, board_p1);
        end
        tests++;
        if (pile !== {7{3'd6}}) begin fails++; $display("FAIL fill_piles: got %h want %h", pile, {7{3'd6}}); end
        req_valid = 1'b1; req_col = 3'd1; any_resp = 1'b0;
        for (int i = 0; i < 6; i++) begin cyc(); if (resp_valid) any_resp = 1'b1; end
        req_valid = 1'b0;
        tests++;
        if (any_resp !== 1'b0) begin fails++; $display("FAIL full_ignores_req: resp seen=%b want 0", any_resp); end
        do_reset(1'b1);
        tests++;
        if (full !== 1'b0 || req_ready !== 1'b1 || player !== 1'b0 || pile !== 21'd0 || board_p0 !== 42'd0 || board_p1 !== 42'd0) begin
            fails++; $display("FAIL clear_after_full: full=%b rdy=%b pl=%b pile=%h p0=%h p1=%h", full, req_ready, player, pile, board_p0, board_p1);
        end
    endtask

    task automatic test_clear_in_check();
        logic seen, ok, rdy; logic [2:0] row; int lat; logic any_resp;
        do_reset(1'b0);
        do_req(3'd1, seen, ok, row, lat, rdy);
        req_valid = 1'b1; req_col = 3'd4;
        cyc();
        req_valid = 1'b0;
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        any_resp = resp_valid;
        for (int i = 0; i < 5; i++) begin if (resp_valid) any_resp = 1'b1; cyc(); end
        tests++;
        if (any_resp !== 1'b0) begin fails++; $display("FAIL clear_check_noresp: resp seen=%b want 0", any_resp); end
        tests++;
        if (player !== 1'b0 || pile !== 21'd0 || board_p0 !== 42'd0 || board_p1 !== 42'd0 || req_ready !== 1'b1) begin
            fails++; $display("FAIL clear_check_state: pl=%b pile=%h p0=%h p1=%h rdy=%b", player, pile, board_p0, board_p1, req_ready);
        end
        do_req(3'd4, seen, ok, row, lat, rdy);
        tests++;
        if (seen !== 1'b1 || ok !== 1'b1 || row !== 3'd0 || board_p0 !== 42'h10 || pile !== 21'h1000) begin
            fails++; $display("FAIL clear_check_next: seen=%b ok=%b row=%0d p0=%h pile=%h, want 1 1 0 10 1000", seen, ok, row, board_p0, pile);
        end
    endtask

`ifdef DROP_ANIM_EN
    task automatic test_anim();
        int bad;
        tick_auto = 1'b0; tick = 1'b0;
        do_reset(1'b0);
        req_valid = 1'b1; req_col = 3'd2;
        cyc();
        req_valid = 1'b0;
        cyc();
        tests++;
        if (anim_valid !== 1'b1 || anim_col !== 3'd2 || anim_row !== 3'd5) begin
            fails++; $display("FAIL anim_start: v=%b col=%0d row=%0d, want 1 2 5", anim_valid, anim_col, anim_row);
        end
        bad = 0;
        for (int t = 1; t <= 12; t++) begin
            tick = 1'b1; cyc(); tick = 1'b0;
            if (t < 12 && (anim_valid !== 1'b1 || anim_row !== 3'(5 - t / 2) || resp_valid !== 1'b0)) bad++;
        end
        tests++;
        if (bad !== 0) begin fails++; $display("FAIL anim_rows: %0d bad tick samples, want 0", bad); end
        tests++;
        if (anim_valid !== 1'b0) begin fails++; $display("FAIL anim_drop: v=%b want 0 after 12 ticks", anim_valid); end
        cyc();
        tests++;
        if (resp_valid !== 1'b1 || resp_ok !== 1'b1 || resp_row !== 3'd0 || board_p0 !== 42'h4) begin
            fails++; $display("FAIL anim_resp: rv=%b ok=%b row=%0d p0=%h, want 1 1 0 4", resp_valid, resp_ok, resp_row, board_p0);
        end
        tick_auto = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_first_move();
        test_col_fill();
        test_illegal_col();
        test_fill_board();
        test_clear_in_check();
`ifdef DROP_ANIM_EN
        test_anim();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
